// File: rtl/mem_bist_march_ctrl_pkg.sv
// Shared types and constants for the March C- BIST sequencer.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ONLY,
    ST_RD,
    ST_WR,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // March element index, M0..M5
  typedef logic [2:0] elem_t;

  localparam elem_t ELEM_M0 = 3'd0;
  localparam elem_t ELEM_M1 = 3'd1;

  // Per-element properties, bit i describes element Mi
  localparam logic [7:0] ELEM_DOWN   = 8'b0011_1000;  // M3, M4, M5 walk downwards
  localparam logic [7:0] ELEM_RD_INV = 8'b0001_0100;  // M2, M4 read back ~P
  localparam logic [7:0] ELEM_WR_INV = 8'b0000_1010;  // M1, M3 write ~P
  localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;  // M5 is read-only

  localparam logic [7:0] RESET_WDATA = 8'hAA;

  // Background pattern P for each patternSel code; ~P is the pair
  function automatic logic [7:0] pattern_of(input logic [1:0] sel);
    case (sel)
      2'b00:   return 8'h00;
      2'b01:   return 8'h55;
      2'b10:   return 8'h33;
      default: return 8'h0F;
    endcase
  endfunction

endpackage

// File: rtl/mem_bist_march_ctrl_if.sv
// Parallel memory test port driven by the BIST sequencer.
interface mem_bist_march_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] memAddr_o;
  logic [DATA_WIDTH-1:0] memWrData_o;
  logic                  memWrEn_o;
  logic                  memRdEn_o;
  logic [DATA_WIDTH-1:0] memRdData_i;

  modport master (
    output memAddr_o, memWrData_o, memWrEn_o, memRdEn_o,
    input  memRdData_i
  );

  modport slave (
    input  memAddr_o, memWrData_o, memWrEn_o, memRdEn_o,
    output memRdData_i
  );
endinterface

// File: rtl/mem_bist_march_ctrl_addr_gen.sv
// Up/down address counter for the March sequencer with terminal-count flag.
module mem_bist_addr_gen #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_ADDR   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load_lo,
  input  logic                  i_load_hi,
  input  logic                  i_step,
  input  logic                  i_down,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_tc
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MAX_ADDR - 1);

  logic [ADDR_WIDTH-1:0] r_addr;

  // Address register: loads take priority over stepping
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_addr <= '0;
    else if (i_load_lo) r_addr <= '0;
    else if (i_load_hi) r_addr <= LAST;
    else if (i_step)    r_addr <= i_down ? r_addr - 1'b1 : r_addr + 1'b1;
  end

  assign o_addr = r_addr;
  assign o_tc   = i_down ? (r_addr == '0) : (r_addr == LAST);
endmodule

// File: rtl/mem_bist_march_ctrl.sv
// March C- BIST sequencer for one memory port.
// Optional first-fail address capture: define MEM_BIST_FAIL_LOG_EN.
module mem_bist_march_ctrl
  import mem_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADDR   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [1:0]             patternSel_i,
  mem_bist_march_ctrl_if.master  mem,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [7:0]             failCount_o,
  output logic [ADDR_WIDTH-1:0]  firstFailAddr_o
);
  state_t r_state, w_nxt_state;
  elem_t  r_elem, w_nxt_elem;
  logic [7:0] r_pat, w_pat;
  logic r_wr_en, r_rd_en, r_rd_d1;
  logic [DATA_WIDTH-1:0] r_wdata, w_nxt_wdata, w_exp;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic w_tc, w_load_lo, w_load_hi, w_step, w_down;
  logic w_start, w_cmp, w_mismatch;
  logic [7:0] r_fail_cnt;
  logic r_done, r_pass;

  assign w_start = (r_state == ST_IDLE || r_state == ST_DONE) && start_i && !abort_i;
  assign w_pat   = w_start ? pattern_of(patternSel_i) : r_pat;
  assign w_down  = ELEM_DOWN[r_elem];

  mem_bist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MAX_ADDR   (MAX_ADDR)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .i_load_lo (w_load_lo),
    .i_load_hi (w_load_hi),
    .i_step    (w_step),
    .i_down    (w_down),
    .o_addr    (w_addr),
    .o_tc      (w_tc)
  );

  // Next state, element and address-counter command
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_elem  = r_elem;
    w_load_lo   = 1'b0;
    w_load_hi   = 1'b0;
    w_step      = 1'b0;
    if (abort_i) begin
      w_nxt_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (start_i) begin
          w_nxt_state = ST_WR_ONLY;
          w_nxt_elem  = ELEM_M0;
          w_load_lo   = 1'b1;
        end
        ST_WR_ONLY: if (w_tc) begin
          w_nxt_state = ST_RD;
          w_nxt_elem  = ELEM_M1;
          w_load_lo   = 1'b1;
        end else begin
          w_step = 1'b1;
        end
        ST_RD: if (ELEM_HAS_WR[r_elem]) begin
          w_nxt_state = ST_WR;
        end else if (w_tc) begin
          w_nxt_state = ST_DRAIN;
        end else begin
          w_step = 1'b1;
        end
        ST_WR: begin
          w_nxt_state = ST_RD;
          if (w_tc) begin
            w_nxt_elem = r_elem + 3'd1;
            if (ELEM_DOWN[w_nxt_elem]) w_load_hi = 1'b1;
            else                       w_load_lo = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
        ST_DRAIN: w_nxt_state = ST_DONE;
        default:  w_nxt_state = ST_IDLE;
      endcase
    end
  end

  // Write data presented with the next state; held outside write cycles
  always_comb begin
    w_nxt_wdata = r_wdata;
    if (w_nxt_state == ST_WR_ONLY)
      w_nxt_wdata = DATA_WIDTH'(w_pat);
    else if (w_nxt_state == ST_WR)
      w_nxt_wdata = DATA_WIDTH'(ELEM_WR_INV[w_nxt_elem] ? ~w_pat : w_pat);
  end

  // Read data lands one cycle after the read strobe; M5 reads therefore
  // compare in the following RD or DRAIN cycle, M1-M4 reads in their WR cycle.
  assign w_exp      = DATA_WIDTH'(ELEM_RD_INV[r_elem] ? ~r_pat : r_pat);
  assign w_cmp      = r_rd_d1 && (r_state == ST_WR || r_state == ST_RD || r_state == ST_DRAIN);
  assign w_mismatch = w_cmp && (mem.memRdData_i != w_exp);

  // FSM state, latched pattern and registered memory strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_elem  <= ELEM_M0;
      r_pat   <= '0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_rd_d1 <= 1'b0;
      r_wdata <= DATA_WIDTH'(RESET_WDATA);
    end else begin
      r_state <= w_nxt_state;
      r_elem  <= w_nxt_elem;
      r_wr_en <= (w_nxt_state == ST_WR_ONLY) || (w_nxt_state == ST_WR);
      r_rd_en <= (w_nxt_state == ST_RD);
      r_rd_d1 <= r_rd_en;
      r_wdata <= w_nxt_wdata;
      if (w_start) r_pat <= pattern_of(patternSel_i);
    end
  end

  // Saturating fail counter and end-of-test result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fail_cnt <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else if (w_start) begin
      r_fail_cnt <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      if (w_mismatch && r_fail_cnt != 8'hFF) r_fail_cnt <= r_fail_cnt + 8'd1;
      if (r_state == ST_DRAIN && !abort_i) begin
        r_done <= 1'b1;
        r_pass <= (r_fail_cnt == '0) && !w_mismatch;
      end
    end
  end

`ifdef MEM_BIST_FAIL_LOG_EN
  logic [ADDR_WIDTH-1:0] r_addr_d1, r_first_fail;

  // Read address of the data being compared, and the first failing one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_d1    <= '0;
      r_first_fail <= '0;
    end else begin
      r_addr_d1 <= w_addr;
      if (w_start)
        r_first_fail <= '0;
      else if (w_mismatch && r_fail_cnt == '0)
        r_first_fail <= r_addr_d1;
    end
  end

  assign firstFailAddr_o = r_first_fail;
`else
  assign firstFailAddr_o = '0;
`endif

  assign mem.memAddr_o   = w_addr;
  assign mem.memWrData_o = r_wdata;
  assign mem.memWrEn_o   = r_wr_en;
  assign mem.memRdEn_o   = r_rd_en;
  assign busy_o      = (r_state == ST_WR_ONLY) || (r_state == ST_RD) ||
                       (r_state == ST_WR) || (r_state == ST_DRAIN);
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign failCount_o = r_fail_cnt;
endmodule

// File: tb/tb_mem_bist_march_ctrl.sv
// Self-checking bench: three sequencer instances (N = 32, 2, 64) each with a
// behavioural memory; a March C- trace model predicts every busy cycle.
`timescale 1ns/1ps
module tb_mem_bist_march_ctrl;
  localparam int NI = 3;

  function automatic int n_of(input int k);
    return (k == 0) ? 32 : (k == 1) ? 2 : 64;
  endfunction

  function automatic logic [7:0] pat_tab(input logic [1:0] ps);
    case (ps)
      2'b00:   return 8'h00;
      2'b01:   return 8'h55;
      2'b10:   return 8'h33;
      default: return 8'h0F;
    endcase
  endfunction

  // 0 = clean, 1 = bit0 stuck at 1 on address 5, 2 = every read returns 0
  function automatic logic [7:0] fault_read(input int mode, input logic [7:0] a,
                                            input logic [7:0] v);
    if (mode == 1 && a == 8'd5) return v | 8'h01;
    if (mode == 2) return 8'h00;
    return v;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a[NI], start_a[NI], abort_a[NI];
  logic [1:0] psel_a[NI];
  int         fault_a[NI];
  logic [7:0] t_addr[NI], t_wdata[NI], t_fail[NI], t_ffa[NI];
  logic       t_wr[NI], t_rd[NI], t_busy[NI], t_done[NI], t_pass[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int N = (g == 0) ? 32 : (g == 1) ? 2 : 64;
    mem_bist_march_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();
    logic [7:0] mem [256];
    logic [7:0] rdata;

    mem_bist_march_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_ADDR(N)) dut (
      .clk             (clk),
      .reset           (rst_a[g]),
      .start_i         (start_a[g]),
      .abort_i         (abort_a[g]),
      .patternSel_i    (psel_a[g]),
      .mem             (bus),
      .busy_o          (t_busy[g]),
      .done_o          (t_done[g]),
      .pass_o          (t_pass[g]),
      .failCount_o     (t_fail[g]),
      .firstFailAddr_o (t_ffa[g])
    );

    always @(posedge clk) begin
      if (bus.memWrEn_o) mem[bus.memAddr_o] <= bus.memWrData_o;
      if (bus.memRdEn_o) rdata <= fault_read(fault_a[g], bus.memAddr_o, mem[bus.memAddr_o]);
    end
    assign bus.memRdData_i = rdata;
    assign t_addr[g]  = bus.memAddr_o;
    assign t_wdata[g] = bus.memWrData_o;
    assign t_wr[g]    = bus.memWrEn_o;
    assign t_rd[g]    = bus.memRdEn_o;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       wr;
    logic       rd;
    logic       chk;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cyc_t;

  cyc_t       exp_q[$];
  cyc_t       cur_c;
  int         seen_addr[$];
  int         cur = 0;
  bit         armed = 0;
  bit         finished = 0;
  logic [7:0] exp_fail, exp_ffa;
  logic       exp_pass;

  // Expected per-cycle trace of one March C- run, plus its final verdict
  task automatic build_model(input int k, input logic [1:0] ps);
    int n, fails, first, a;
    logic [7:0] p, expd, obs, wv;
    logic [7:0] mm [256];
    n = n_of(k);
    p = pat_tab(ps);
    fails = 0;
    first = -1;
    exp_q.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < n; i++) begin
        a = (e >= 3) ? n - 1 - i : i;
        if (e >= 1) begin
          expd = (e == 2 || e == 4) ? ~p : p;
          obs  = fault_read(fault_a[k], 8'(a), mm[a]);
          if (obs != expd) begin
            fails++;
            if (first < 0) first = a;
          end
          exp_q.push_back('{wr: 1'b0, rd: 1'b1, chk: 1'b1, addr: 8'(a), wdata: 8'h00});
        end
        if (e <= 4) begin
          wv = (e == 1 || e == 3) ? ~p : p;
          mm[a] = wv;
          exp_q.push_back('{wr: 1'b1, rd: 1'b0, chk: 1'b1, addr: 8'(a), wdata: wv});
        end
      end
    end
    exp_q.push_back('{wr: 1'b0, rd: 1'b0, chk: 1'b0, addr: 8'h00, wdata: 8'h00});
    exp_fail = (fails > 255) ? 8'd255 : 8'(fails);
    exp_pass = (fails == 0);
`ifdef MEM_BIST_FAIL_LOG_EN
    exp_ffa = (first < 0) ? 8'd0 : 8'(first);
`else
    exp_ffa = 8'd0;
`endif
  endtask

  // Cycle-by-cycle comparison of the active instance against the trace
  always @(negedge clk) begin
    if (armed) begin
      if (exp_q.size() > 0) begin
        cur_c = exp_q.pop_front();
        check("busy", t_busy[cur], 1);
        check("wr_en", t_wr[cur], cur_c.wr);
        check("rd_en", t_rd[cur], cur_c.rd);
        if (cur_c.chk) check("addr", t_addr[cur], cur_c.addr);
        if (cur_c.wr)  check("wdata", t_wdata[cur], cur_c.wdata);
        if (cur == 1 && cur_c.chk) seen_addr.push_back(int'(t_addr[1]));
      end else begin
        check("end_busy", t_busy[cur], 0);
        check("end_done", t_done[cur], 1);
        check("end_pass", t_pass[cur], exp_pass);
        check("end_failcount", t_fail[cur], exp_fail);
        check("end_firstfail", t_ffa[cur], exp_ffa);
        check("end_enables", {t_wr[cur], t_rd[cur]}, 0);
        armed    = 0;
        finished = 1;
      end
    end
  end

  task automatic launch(input int k, input logic [1:0] ps, input bit track);
    @(negedge clk);
    psel_a[k]  = ps;
    start_a[k] = 1'b1;
    if (track) begin
      cur = k;
      build_model(k, ps);
    end
    @(posedge clk);
    #1;
    start_a[k] = 1'b0;
    if (track) begin
      finished = 0;
      armed    = 1;
    end
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (!finished && i < 2000) begin
      @(posedge clk);
      i++;
    end
    check("run_completes", finished, 1);
    armed = 0;
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input int k, input string tag);
    check({tag, "_addr"}, t_addr[k], 8'h00);
    check({tag, "_wdata"}, t_wdata[k], 8'hAA);
    check({tag, "_enables"}, {t_wr[k], t_rd[k]}, 0);
    check({tag, "_busy"}, t_busy[k], 0);
    check({tag, "_done_pass"}, {t_done[k], t_pass[k]}, 0);
    check({tag, "_failcount"}, t_fail[k], 0);
    check({tag, "_firstfail"}, t_ffa[k], 0);
  endtask

  initial begin
    int exp_seq[20];
    logic [7:0] ffa5;
`ifdef MEM_BIST_FAIL_LOG_EN
    ffa5 = 8'd5;
`else
    ffa5 = 8'd0;
`endif
    exp_seq = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0};
    for (int k = 0; k < NI; k++) begin
      rst_a[k] = 1'b1; start_a[k] = 1'b0; abort_a[k] = 1'b0;
      psel_a[k] = 2'b00; fault_a[k] = 0;
    end
    #12;
    for (int k = 0; k < NI; k++) check_reset_vals(k, "reset");
    #10;
    for (int k = 0; k < NI; k++) rst_a[k] = 1'b0;

    // Clean run, P=55, with an ignored start pulse mid-test
    launch(0, 2'b01, 1);
    check("model_len_n32", exp_q.size(), 321);
    check("model_first_wdata", exp_q[0].wdata, 8'h55);
    repeat (50) @(posedge clk);
    @(negedge clk);
    start_a[0] = 1'b1; psel_a[0] = 2'b11;
    @(negedge clk);
    start_a[0] = 1'b0;
    wait_done();
    check("clean_done", t_done[0], 1);
    check("clean_pass", t_pass[0], 1);
    check("clean_failcount", t_fail[0], 0);

    // Stuck-at-1 bit0 at address 5, P=00: only M1, M3, M5 can see it
    fault_a[0] = 1;
    launch(0, 2'b00, 1);
    check("model_stuck_fails", exp_fail, 3);
    wait_done();
    check("stuck_failcount", t_fail[0], 3);
    check("stuck_pass", t_pass[0], 0);
    check("stuck_firstfail", t_ffa[0], ffa5);

    // All-zero reads on N=64 with P=55: 320 mismatches saturate at 255
    fault_a[2] = 2;
    launch(2, 2'b01, 1);
    wait_done();
    check("sat_failcount", t_fail[2], 255);
    check("sat_pass", t_pass[2], 0);

    // Abort during M2 at address 10 keeps the count and does not finish
    launch(0, 2'b00, 0);
    repeat (116) @(posedge clk);
    @(negedge clk);
    check("abort_at_addr", t_addr[0], 10);
    check("abort_at_rd", t_rd[0], 1);
    check("abort_pre_failcount", t_fail[0], 1);
    abort_a[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_a[0] = 1'b0;
    check("abort_enables", {t_wr[0], t_rd[0]}, 0);
    check("abort_busy", t_busy[0], 0);
    check("abort_done", t_done[0], 0);
    check("abort_failcount", t_fail[0], 1);
    fault_a[0] = 0;
    launch(0, 2'b10, 1);
    wait_done();

    // Reset asserted mid-M3 clears everything immediately
    fault_a[0] = 1;
    launch(0, 2'b00, 0);
    repeat (169) @(posedge clk);
    @(negedge clk);
    check("m3_busy", t_busy[0], 1);
    check("m3_failcount", t_fail[0], 1);
    check("m3_firstfail", t_ffa[0], ffa5);
    rst_a[0] = 1'b1;
    #1;
    check_reset_vals(0, "midreset");
    #2;
    rst_a[0] = 1'b0;
    @(negedge clk);
    check_reset_vals(0, "postreset");

    // Smallest memory, N=2: full address sequence
    seen_addr.delete();
    launch(1, 2'b11, 1);
    check("model_len_n2", exp_q.size(), 21);
    wait_done();
    check("n2_seq_len", seen_addr.size(), 20);
    for (int i = 0; i < 20 && i < seen_addr.size(); i++)
      check("n2_addr_seq", seen_addr[i], exp_seq[i]);
    check("n2_pass", t_pass[1], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
